// File: rtl/vga_pkg.sv
// Shared VGA types and 640x480@60 timing constants for the scan driver.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned COORD_W = 11;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic fs;
        logic ls;
    } vga_status_t;

    // Tuple used to pre-fill the delay line: blanked, no sync, no pulses.
    localparam vga_status_t STATUS_BLANK = '{hs: 1'b0, vs: 1'b0, active: 1'b0, fs: 1'b0, ls: 1'b0};

    // Half-open window test lo <= c < hi on a raw counter value.
    function automatic logic in_window(input logic [COORD_W-1:0] c,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with asynchronous clear to a supplied value.
module vga_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 occupies the low WIDTH bits; the oldest entry sits at the top.
    logic [DEPTH*WIDTH-1:0] chain_reg;
    logic [DEPTH*WIDTH-1:0] chain_next;

    generate
        if (DEPTH == 1) begin : g_single
            assign chain_next = i_d;
        end else begin : g_multi
            assign chain_next = {chain_reg[(DEPTH-1)*WIDTH-1:0], i_d};
        end
    endgenerate

    // Shift one entry per enabled tick; clear every stage to the reset tuple.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain_reg <= {DEPTH{i_rst_val}};
        end else if (i_en) begin
            chain_reg <= chain_next;
        end
    end

    assign o_q = chain_reg[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_scan_driver.sv
// VGA pixel-timing source: issues scan coordinates to the renderer chain and
// re-aligns the returned RGB with HS/VS/BLANK after a fixed pipeline delay.
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    input  logic [7:0]  i_VGA_R,
    input  logic [7:0]  i_VGA_G,
    input  logic [7:0]  i_VGA_B,
    output logic [10:0] o_VGA_X,
    output logic [10:0] o_VGA_Y,
    output logic        o_req_active,
    output logic [7:0]  o_VGA_R,
    output logic [7:0]  o_VGA_G,
    output logic [7:0]  o_VGA_B,
    output logic        o_VGA_HS,
    output logic        o_VGA_VS,
    output logic        o_VGA_BLANK_N,
    output logic        o_VGA_SYNC_N,
    output logic        o_frame_start,
    output logic        o_line_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned STATUS_W = $bits(vga_status_t);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // The counters themselves are the registered request coordinate.
    logic [10:0] h_reg, v_reg;
    logic [10:0] h_next, v_next;
    logic        req_active_reg;

    rgb_t                in_rgb;
    rgb_t                rgb_reg;
    logic                blank_n_reg, hs_reg, vs_reg;
    logic                frame_start_reg, line_start_reg;
    vga_status_t         st_now;
    vga_status_t         st_d;
    logic [STATUS_W-1:0] st_d_bits;

    assign in_rgb = '{r: i_VGA_R, g: i_VGA_G, b: i_VGA_B};

    // Next raster position: h wraps at line end, v advances on h wrap.
    always_comb begin
        h_next = (h_reg == H_LAST) ? 11'd0 : h_reg + 11'd1;
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            v_next = (v_reg == V_LAST) ? 11'd0 : v_reg + 11'd1;
        end
    end

    // Request timeline: advance the scan position once per pixel tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_reg          <= 11'd0;
            v_reg          <= 11'd0;
            req_active_reg <= 1'b1;
        end else if (i_pix_en) begin
            h_reg          <= h_next;
            v_reg          <= v_next;
            req_active_reg <= (h_next < H_ACT) && (v_next < V_ACT);
        end
    end

    // Status of the coordinate currently presented to the renderers.
    always_comb begin
        st_now        = STATUS_BLANK;
        st_now.hs     = in_window(h_reg, HS_START, HS_END);
        st_now.vs     = in_window(v_reg, VS_START, VS_END);
        st_now.active = req_active_reg;
        st_now.fs     = (h_reg == 11'd0) && (v_reg == 11'd0);
        st_now.ls     = (h_reg == 11'd0) && (v_reg < V_ACT);
    end

    // The output register is the last stage of the pipeline, so only
    // PIPE_DELAY-1 extra stages sit between the request and the output.
    generate
        if (PIPE_DELAY > 1) begin : g_delay
            vga_delay_line #(
                .DEPTH (PIPE_DELAY - 1),
                .WIDTH (STATUS_W)
            ) u_status_dly (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_en      (i_pix_en),
                .i_rst_val (STATUS_BLANK),
                .i_d       (st_now),
                .o_q       (st_d_bits)
            );
        end else begin : g_no_delay
            assign st_d_bits = st_now;
        end
    endgenerate

    assign st_d = st_d_bits;

    // Output stage: sample RGB with the matching delayed status; pulses last one clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_reg         <= '0;
            blank_n_reg     <= 1'b0;
            hs_reg          <= !HS_POL;
            vs_reg          <= !VS_POL;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            if (i_pix_en) begin
                rgb_reg         <= st_d.active ? in_rgb : '0;
                blank_n_reg     <= st_d.active;
                hs_reg          <= st_d.hs ? HS_POL : !HS_POL;
                vs_reg          <= st_d.vs ? VS_POL : !VS_POL;
                frame_start_reg <= st_d.fs;
                line_start_reg  <= st_d.ls;
            end
        end
    end

    assign o_VGA_X       = h_reg;
    assign o_VGA_Y       = v_reg;
    assign o_req_active  = req_active_reg;
    assign o_VGA_R       = rgb_reg.r;
    assign o_VGA_G       = rgb_reg.g;
    assign o_VGA_B       = rgb_reg.b;
    assign o_VGA_HS      = hs_reg;
    assign o_VGA_VS      = vs_reg;
    assign o_VGA_BLANK_N = blank_n_reg;
    assign o_VGA_SYNC_N  = 1'b0;
    assign o_frame_start = frame_start_reg;
    assign o_line_start  = line_start_reg;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: three instances (default timing with delay 1 and
// 3, plus a small raster with delay 2) checked against a linear-index model.
module tb_vga_scan_driver;

    localparam int NI = 3;

    // Small raster for the third instance: 24 x 17 = 408 ticks per frame.
    localparam int S_HA = 16, S_HFP = 2, S_HSY = 3, S_HBP = 3;
    localparam int S_VA = 10, S_VFP = 2, S_VSY = 2, S_VBP = 3;
    localparam int S_PD = 2;

    int p_ha[NI]  = '{640, 640, S_HA};
    int p_hfp[NI] = '{16, 16, S_HFP};
    int p_hsy[NI] = '{96, 96, S_HSY};
    int p_hbp[NI] = '{48, 48, S_HBP};
    int p_va[NI]  = '{480, 480, S_VA};
    int p_vfp[NI] = '{10, 10, S_VFP};
    int p_vsy[NI] = '{2, 2, S_VSY};
    int p_vbp[NI] = '{33, 33, S_VBP};
    int p_pd[NI]  = '{1, 3, S_PD};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pix_en;
    logic [7:0] in_r, in_g, in_b;

    logic [NI-1:0][10:0] o_x, o_y;
    logic [NI-1:0][7:0]  o_r, o_g, o_b;
    logic [NI-1:0]       o_req, o_hs, o_vs, o_bn, o_sn, o_fs, o_ls;

    vga_scan_driver #(.PIPE_DELAY(1)) dut_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .i_VGA_R(in_r), .i_VGA_G(in_g), .i_VGA_B(in_b),
        .o_VGA_X(o_x[0]), .o_VGA_Y(o_y[0]), .o_req_active(o_req[0]),
        .o_VGA_R(o_r[0]), .o_VGA_G(o_g[0]), .o_VGA_B(o_b[0]),
        .o_VGA_HS(o_hs[0]), .o_VGA_VS(o_vs[0]), .o_VGA_BLANK_N(o_bn[0]),
        .o_VGA_SYNC_N(o_sn[0]), .o_frame_start(o_fs[0]), .o_line_start(o_ls[0])
    );

    vga_scan_driver #(.PIPE_DELAY(3)) dut_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .i_VGA_R(in_r), .i_VGA_G(in_g), .i_VGA_B(in_b),
        .o_VGA_X(o_x[1]), .o_VGA_Y(o_y[1]), .o_req_active(o_req[1]),
        .o_VGA_R(o_r[1]), .o_VGA_G(o_g[1]), .o_VGA_B(o_b[1]),
        .o_VGA_HS(o_hs[1]), .o_VGA_VS(o_vs[1]), .o_VGA_BLANK_N(o_bn[1]),
        .o_VGA_SYNC_N(o_sn[1]), .o_frame_start(o_fs[1]), .o_line_start(o_ls[1])
    );

    vga_scan_driver #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(S_PD)
    ) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .i_VGA_R(in_r), .i_VGA_G(in_g), .i_VGA_B(in_b),
        .o_VGA_X(o_x[2]), .o_VGA_Y(o_y[2]), .o_req_active(o_req[2]),
        .o_VGA_R(o_r[2]), .o_VGA_G(o_g[2]), .o_VGA_B(o_b[2]),
        .o_VGA_HS(o_hs[2]), .o_VGA_VS(o_vs[2]), .o_VGA_BLANK_N(o_bn[2]),
        .o_VGA_SYNC_N(o_sn[2]), .o_frame_start(o_fs[2]), .o_line_start(o_ls[2])
    );

    int checks = 0;
    int errors = 0;
    int n_tick;
    int last_fs;
    int ls_cnt;

    int ex_x[NI], ex_y[NI], ex_req[NI];
    int ex_r[NI], ex_g[NI], ex_b[NI];
    int ex_hs[NI], ex_vs[NI], ex_bn[NI], ex_fs[NI], ex_ls[NI];

    function automatic void model_reset();
        n_tick = 0;
        for (int k = 0; k < NI; k++) begin
            ex_x[k] = 0;  ex_y[k] = 0;  ex_req[k] = 1;
            ex_r[k] = 0;  ex_g[k] = 0;  ex_b[k] = 0;
            ex_hs[k] = 1; ex_vs[k] = 1; ex_bn[k] = 0;
            ex_fs[k] = 0; ex_ls[k] = 0;
        end
    endfunction

    // After tick n the request shows raster index n; the output shows index n-D
    // (nothing visible yet while n-D is negative), coloured with this tick's RGB.
    function automatic void model_tick(input int r, input int g, input int b);
        n_tick++;
        for (int k = 0; k < NI; k++) begin
            int ht, vt, p, q, qx, qy, hs0, vs0;
            bit vis;
            ht = p_ha[k] + p_hfp[k] + p_hsy[k] + p_hbp[k];
            vt = p_va[k] + p_vfp[k] + p_vsy[k] + p_vbp[k];
            p = n_tick % (ht * vt);
            ex_x[k] = p % ht;
            ex_y[k] = p / ht;
            ex_req[k] = (ex_x[k] < p_ha[k] && ex_y[k] < p_va[k]) ? 1 : 0;
            q = n_tick - p_pd[k];
            if (q < 0) begin
                ex_r[k] = 0; ex_g[k] = 0; ex_b[k] = 0;
                ex_hs[k] = 1; ex_vs[k] = 1; ex_bn[k] = 0;
                ex_fs[k] = 0; ex_ls[k] = 0;
            end else begin
                q = q % (ht * vt);
                qx = q % ht;
                qy = q / ht;
                vis = (qx < p_ha[k]) && (qy < p_va[k]);
                hs0 = p_ha[k] + p_hfp[k];
                vs0 = p_va[k] + p_vfp[k];
                ex_bn[k] = vis ? 1 : 0;
                ex_r[k] = vis ? r : 0;
                ex_g[k] = vis ? g : 0;
                ex_b[k] = vis ? b : 0;
                ex_hs[k] = (qx >= hs0 && qx < hs0 + p_hsy[k]) ? 0 : 1;
                ex_vs[k] = (qy >= vs0 && qy < vs0 + p_vsy[k]) ? 0 : 1;
                ex_fs[k] = (qx == 0 && qy == 0) ? 1 : 0;
                ex_ls[k] = (qx == 0 && qy < p_va[k]) ? 1 : 0;
            end
        end
    endfunction

    function automatic void model_idle();
        for (int k = 0; k < NI; k++) begin
            ex_fs[k] = 0;
            ex_ls[k] = 0;
        end
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h (tick %0d)", tag, k, obs, exp, n_tick);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk("X", k, 32'(o_x[k]), ex_x[k]);
            chk("Y", k, 32'(o_y[k]), ex_y[k]);
            chk("REQ_ACTIVE", k, 32'(o_req[k]), ex_req[k]);
            chk("R", k, 32'(o_r[k]), ex_r[k]);
            chk("G", k, 32'(o_g[k]), ex_g[k]);
            chk("B", k, 32'(o_b[k]), ex_b[k]);
            chk("HS", k, 32'(o_hs[k]), ex_hs[k]);
            chk("VS", k, 32'(o_vs[k]), ex_vs[k]);
            chk("BLANK_N", k, 32'(o_bn[k]), ex_bn[k]);
            chk("SYNC_N", k, 32'(o_sn[k]), 32'd0);
            chk("FRAME_START", k, 32'(o_fs[k]), ex_fs[k]);
            chk("LINE_START", k, 32'(o_ls[k]), ex_ls[k]);
        end
    endtask

    // One clock: drive enable, apply the edge to the model, check at the falling edge.
    task automatic step(input logic en);
        bit tick;
        pix_en = en;
        @(posedge clk);
        tick = rst_n && en;
        if (!rst_n) model_reset();
        else if (en) model_tick(int'(in_r), int'(in_g), int'(in_b));
        else model_idle();
        @(negedge clk);
        check_all();
        if (tick && o_fs[2] === 1'b1) begin
            if (last_fs >= 0) begin
                chk("FRAME_SPAN", 2, 32'(n_tick - last_fs), 32'd408);
                chk("LINES_PER_FRAME", 2, 32'(ls_cnt), 32'(S_VA));
            end
            last_fs = n_tick;
            ls_cnt = 0;
        end
        if (tick && o_ls[2] === 1'b1) ls_cnt++;
    endtask

    task automatic rand_rgb();
        in_r = 8'($urandom);
        in_g = 8'($urandom);
        in_b = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        pix_en = 1'b1;
        in_r = 8'h00; in_g = 8'h00; in_b = 8'h00;
        last_fs = -1;
        ls_cnt = 0;
        model_reset();
        @(negedge clk);
        check_all();
        repeat (3) step(1'b1);

        // Continuous ticks with constant red: line wraps, sync windows, blanking.
        rst_n = 1'b1;
        repeat (2500) begin
            in_r = 8'hAB;
            in_g = 8'($urandom);
            in_b = 8'($urandom);
            step(1'b1);
        end

        // Random pixel-enable gaps: outputs hold, pulses stay one clock wide.
        repeat (3000) begin
            rand_rgb();
            step(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-frame takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        model_reset();
        last_fs = -1;
        ls_cnt = 0;
        check_all();
        @(negedge clk);
        repeat (2) step(1'b1);
        rst_n = 1'b1;
        repeat (900) begin
            rand_rgb();
            step(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
Pixel-timing source that drives the downstream VGA DAC and feeds the layer renderers. Each pixel tick it issues a scan coordinate (o_VGA_X/o_VGA_Y) to the renderer chain. It then samples the returned RGB a fixed number of ticks later. It emits that RGB with HS/VS/BLANK delayed to match, so the colour and sync signals stay aligned at the connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, active level of HS (0 = active-low)
VS_POL, 0, active level of VS
PIPE_DELAY, 1, pixel ticks from coordinate issue to valid RGB at input; legal range 1..8

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_pix_en  in  1  pixel-tick enable; all state advances only on cycles with i_pix_en=1
i_VGA_R  in  8  red returned by renderer chain
i_VGA_G  in  8  green returned by renderer chain
i_VGA_B  in  8  blue returned by renderer chain
o_VGA_X  out  11  requested column (raw h counter, 0..H_TOTAL-1)
o_VGA_Y  out  11  requested row (raw v counter, 0..V_TOTAL-1)
o_req_active  out  1  requested coordinate lies in the visible area
o_VGA_R  out  8  red to DAC, zero while blanked
o_VGA_G  out  8  green to DAC
o_VGA_B  out  8  blue to DAC
o_VGA_HS  out  1  horizontal sync, output timeline
o_VGA_VS  out  1  vertical sync, output timeline
o_VGA_BLANK_N  out  1  high while output pixel is visible
o_VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
o_frame_start  out  1  one-cycle pulse when output timeline emits pixel (0,0)
o_line_start  out  1  one-cycle pulse when output timeline emits h=0 of a visible line

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Computed at elaboration; counters are 11-bit.
- Reset (async, i_rst_n=0) values:
  - h/v counters 0; o_VGA_X=0, o_VGA_Y=0, o_req_active=1.
  - Delay line filled with blank/inactive entries.
  - o_VGA_R/G/B=0, o_VGA_BLANK_N=0, o_frame_start=0, o_line_start=0.
  - o_VGA_HS=!HS_POL, o_VGA_VS=!VS_POL (sync deasserted).
- Request timeline:
  - On each i_pix_en tick, h increments.
  - When h=H_TOTAL-1, h wraps to 0 and v increments.
  - When v=V_TOTAL-1 and h wraps, v wraps to 0.
  - o_VGA_X/o_VGA_Y are registered copies of h/v.
  - o_req_active = (h<H_ACTIVE)&&(v<V_ACTIVE).
- Per-tick status derived from the request coordinate:
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - active = o_req_active
  - fs = (h==0 && v==0)
  - ls = (h==0 && v<V_ACTIVE)
- Delay line: the status tuple enters a PIPE_DELAY-deep shift register that advances only on i_pix_en.
- Output stage, registered on the i_pix_en tick at which the tuple exits the delay line:
  - o_VGA_R/G/B = active_d ? i_VGA_* : 0.
  - o_VGA_BLANK_N = active_d.
  - o_VGA_HS = hs_d ? HS_POL : !HS_POL (VS likewise).
- Latency: a coordinate issued on tick k has its RGB sampled on tick k+PIPE_DELAY. That pixel appears on the outputs after the clock edge of that tick.
- o_frame_start/o_line_start are high for exactly the single i_clk cycle following that tick's edge, then 0, even if i_pix_en stays high.
- i_pix_en=0: counters, delay line and all outputs hold. Pulse outputs deassert.
- Reset mid-frame: everything returns to reset values immediately. The first tick after release issues (1,0), since (0,0) was presented during reset. o_frame_start fires PIPE_DELAY ticks after release.
- No input handshake: the renderer is assumed to meet the fixed PIPE_DELAY; RGB is sampled unconditionally.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480@60 timing constants
  - rgb_t (struct of three 8-bit channels)
  - vga_status_t (hs, vs, active, fs, ls)
- One sub-module, vga_delay_line: parameterised depth and width, enable-gated shift register with async active-low clear to a supplied reset value. Instantiated once for the status tuple.

Test Plan:
- Reset with i_pix_en=1, then release -> HS=1, VS=1, BLANK_N=0, RGB=0 during reset; first request after release is X=1,Y=0; o_frame_start pulses exactly PIPE_DELAY(1) ticks later.
- Run one line -> o_VGA_X goes 799->0 with o_VGA_Y 0->1; o_req_active low for X=640..799.
- Check output timeline over one line -> HS low exactly for output pixels h=656..751 (96 ticks); BLANK_N high for h=0..639; repeat with PIPE_DELAY=3 and confirm a 3-tick shift.
- Run a full frame -> VS low on lines 490-491 only; Y wraps 524->0; one o_frame_start and 480 o_line_start pulses per frame.
- Drive i_VGA_R=8'hAB constantly -> o_VGA_R=8'hAB on visible pixels, 0 on blanked pixels including h=640 and v=480.
- Toggle i_pix_en at 50% with random gaps -> no output changes on i_pix_en=0 cycles; frame still spans exactly 420000 ticks; pulses stay one cycle wide.
